// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: counters, latency-matched sync/blank/colour outputs.
// Optional colour-bar pattern is built only when VGA_TEST_PATTERN_EN is defined.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int COLOR_W  = 3,
    parameter int CNT_W    = 10,
    parameter int LAT      = 0
) (
    input  logic               CLK_25MH,
    input  logic               RST_N,
    input  logic [COLOR_W-1:0] rgb_in,
    input  logic               test_mode,
    output logic [CNT_W-1:0]   hor_count,
    output logic [CNT_W-1:0]   ver_count,
    output logic [COLOR_W-1:0] RGB,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

    logic active_raw, hs_raw, vs_raw, fs_raw;
    logic act_dly, hs_dly, vs_dly, fs_dly;
    logic [COLOR_W-1:0] pix_sel;

    always_ff @(posedge CLK_25MH) begin
        if (!RST_N) begin
            hor_count <= '0;
            ver_count <= '0;
        end else if (hor_count == H_LAST) begin
            hor_count <= '0;
            ver_count <= (ver_count == V_LAST) ? '0 : ver_count + CNT_W'(1);
        end else begin
            hor_count <= hor_count + CNT_W'(1);
        end
    end

    assign active_raw = (hor_count < H_ACT_C) && (ver_count < V_ACT_C);
    assign hs_raw     = (hor_count >= HS_START) && (hor_count < HS_END);
    assign vs_raw     = (ver_count >= VS_START) && (ver_count < VS_END);
    assign fs_raw     = (hor_count == '0) && (ver_count == '0);

`ifdef VGA_TEST_PATTERN_EN
    logic [CNT_W-1:0] hc_dly;
`endif

    // Flags travel alongside the renderer pipeline so they meet rgb_in on the same edge.
    generate
        if (LAT == 0) begin : g_no_delay
            assign act_dly = active_raw;
            assign hs_dly  = hs_raw;
            assign vs_dly  = vs_raw;
            assign fs_dly  = fs_raw;
`ifdef VGA_TEST_PATTERN_EN
            assign hc_dly  = hor_count;
`endif
        end else begin : g_delay
            logic [LAT-1:0] act_sr, hs_sr, vs_sr, fs_sr;
`ifdef VGA_TEST_PATTERN_EN
            logic [CNT_W-1:0] hc_sr [LAT];
`endif

            always_ff @(posedge CLK_25MH) begin
                if (!RST_N) begin
                    act_sr <= '0;
                    hs_sr  <= '0;
                    vs_sr  <= '0;
                    fs_sr  <= '0;
`ifdef VGA_TEST_PATTERN_EN
                    for (int i = 0; i < LAT; i++) hc_sr[i] <= '0;
`endif
                end else begin
                    act_sr[0] <= active_raw;
                    hs_sr[0]  <= hs_raw;
                    vs_sr[0]  <= vs_raw;
                    fs_sr[0]  <= fs_raw;
`ifdef VGA_TEST_PATTERN_EN
                    hc_sr[0]  <= hor_count;
`endif
                    for (int i = 1; i < LAT; i++) begin
                        act_sr[i] <= act_sr[i-1];
                        hs_sr[i]  <= hs_sr[i-1];
                        vs_sr[i]  <= vs_sr[i-1];
                        fs_sr[i]  <= fs_sr[i-1];
`ifdef VGA_TEST_PATTERN_EN
                        hc_sr[i]  <= hc_sr[i-1];
`endif
                    end
                end
            end

            assign act_dly = act_sr[LAT-1];
            assign hs_dly  = hs_sr[LAT-1];
            assign vs_dly  = vs_sr[LAT-1];
            assign fs_dly  = fs_sr[LAT-1];
`ifdef VGA_TEST_PATTERN_EN
            assign hc_dly  = hc_sr[LAT-1];
`endif
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]         bar_idx;
    logic [COLOR_W-1:0] bar_color;

    assign bar_idx = 3'(hc_dly / CNT_W'(H_ACTIVE / 8));

    always_comb begin
        bar_color      = '0;
        bar_color[2:0] = bar_idx;
    end

    assign pix_sel = test_mode ? bar_color : rgb_in;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign pix_sel          = rgb_in;
`endif

    always_ff @(posedge CLK_25MH) begin
        if (!RST_N) begin
            RGB         <= '0;
            de          <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            RGB         <= act_dly ? pix_sel : '0;
            de          <= act_dly;
            hsync       <= hs_dly ^ SYNC_IDLE;
            vsync       <= vs_dly ^ SYNC_IDLE;
            frame_start <= fs_dly;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator: next-generation replacement for the fixed 640x480 timing block. It runs horizontal and vertical counters from the 25 MHz pixel clock and exports the current pixel coordinate to the game renderer. It accepts the renderer's colour after a configurable pipeline latency, and emits hsync/vsync/blanking/colour aligned to that latency. Sync polarity, porch widths, colour width and an optional built-in colour-bar pattern are all configurable.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, cycles
- H_SYNC, 96: hsync pulse width, cycles
- H_BP, 48: horizontal back porch, cycles
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- SYNC_POL, 0: 0 = syncs active-low, 1 = active-high
- COLOR_W, 3: colour bus width, minimum 3
- CNT_W, 10: counter width; must hold H_TOTAL-1 and V_TOTAL-1
- LAT, 0: renderer latency in cycles from coordinate to rgb_in valid, 0..3
- CLK_25MH input 1: pixel clock, all logic on rising edge
- RST_N input 1: synchronous, active-low reset
- rgb_in input COLOR_W: renderer colour for the coordinate issued LAT cycles earlier
- test_mode input 1: selects colour bars; ignored unless VGA_TEST_PATTERN_EN is defined
- hor_count output CNT_W: current horizontal counter, direct from register
- ver_count output CNT_W: current vertical counter, direct from register
- RGB output COLOR_W: registered colour, zero outside active area
- hsync output 1: registered horizontal sync
- vsync output 1: registered vertical sync
- de output 1: registered display-enable, high for active pixels
- frame_start output 1: one-cycle pulse coinciding with output of pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- hcount increments every cycle and wraps from H_TOTAL-1 to 0.
- vcount increments only on the hcount wrap. It wraps from V_TOTAL-1 to 0 on that same cycle.
- Raw flags are computed from the counters:
  - active = hcount<H_ACTIVE && vcount<V_ACTIVE
  - hs = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752)
  - vs = vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [490,492)
  - fs = hcount==0 && vcount==0
- active, hs, vs and fs pass through a LAT-deep shift register so they line up with rgb_in. The output register then samples them.
- Output register values:
  - RGB = delayed active ? rgb_in : 0
  - de = delayed active
  - hsync = delayed hs XOR ~SYNC_POL (vsync likewise)
  - frame_start = delayed fs
- Reset (RST_N low at a clock edge) sets:
  - hcount = ver_count = 0, all delay stages cleared
  - RGB = 0, de = 0, frame_start = 0
  - hsync = vsync = inactive level (1 when SYNC_POL=0)
- Reset mid-frame: the counters restart at (0,0). Pipeline contents are discarded, so no stale colour or sync is emitted. The first frame_start occurs LAT+1 cycles after RST_N rises.

## Timing
- Total latency from counter value to RGB/hsync/vsync/de/frame_start is LAT+1 cycles.
- With LAT=0, rgb_in is a combinational function of hor_count/ver_count and is registered on the next edge.
- hsync low for exactly H_SYNC cycles per line; vsync low for exactly V_SYNC*H_TOTAL cycles per frame (default polarity).
- Frame period: H_TOTAL*V_TOTAL = 420000 cycles; frame_start period is identical.
- de high for H_ACTIVE consecutive cycles on each of V_ACTIVE lines.

## Configuration
- VGA_TEST_PATTERN_EN:
  - Defined: with test_mode=1, the active-area colour is replaced by eight vertical bars, each H_ACTIVE/8 wide. Bar k outputs value k in the low 3 bits, upper bits zero.
  - Bars are generated from the delayed hcount, so latency is unchanged. test_mode is sampled per pixel.
- Undefined: the bar logic and delayed hcount are absent; test_mode is unconnected and RGB always follows rgb_in.

## Test plan
- Reset: hold RST_N=0 for 3 cycles -> hor_count=0, ver_count=0, RGB=0, de=0, hsync=vsync=1, frame_start=0.
- Defaults, LAT=0: run one line -> hsync=0 exactly for the outputs of hcount 656..751, 96 cycles; de high 640 cycles; hor_count wraps 799->0 and ver_count increments.
- Frame: run 420000 cycles -> vsync=0 for outputs of lines 490-491 (1600 cycles); ver_count wraps 524->0; frame_start pulses exactly once per 420000 cycles.
- LAT=2, rgb_in = registered-twice function of hor_count[2:0] -> RGB at output pixel (5,0) equals 3'b101, and de/hsync edges are shifted by 3 cycles versus the counters.
- Reset asserted at hcount=300, vcount=200 for 1 cycle -> next cycle counters=0, RGB=0, syncs inactive; frame_start 1+LAT cycles after release.
- VGA_TEST_PATTERN_EN defined, test_mode=1, rgb_in=3'b111 -> RGB=0 for pixels 0..79, 1 for 80..159, ..., 7 for 560..639; RGB=0 in blanking.
